pc_fetch_unit: RTL

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

---
 rtl/pc_fetch_pkg.sv | 19 +
 rtl/pc_reg.sv | 28 ++
 rtl/pc_fetch_unit.sv | 119 +++++++++++
 3 files changed

// File: rtl/pc_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: the FSM state type,
// the PC width and the sequential PC step.
package pc_fetch_pkg;

    localparam int PC_WIDTH = 32;
    localparam logic [PC_WIDTH-1:0] PC_INC = 32'd4;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_OUT  = 2'd2
    } fetch_state_t;

    // Clears the byte-offset bits so an address points at a whole word.
    function automatic logic [PC_WIDTH-1:0] word_align(input logic [PC_WIDTH-1:0] addr);
        return {addr[PC_WIDTH-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter register with asynchronous reset. A load (redirect)
// always wins over a sequential increment. The increment wraps modulo
// 2^32 naturally through the fixed-width add.
import pc_fetch_pkg::*;

module pc_reg #(
    parameter logic [PC_WIDTH-1:0] RESET_PC = 32'h0040_0000
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                load,
    input  logic [PC_WIDTH-1:0] load_value,
    input  logic                inc,
    output logic [PC_WIDTH-1:0] pc
);

    // Hold, redirect or step the PC; reset returns it to the boot address.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= load_value;
        end else if (inc) begin
            pc <= pc + PC_INC;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction fetch unit: issues one request at a time to instruction
// memory, captures the returned word and hands it to decode. Redirects
// (BR_VALID) override everything; a response already in flight when a
// redirect arrives is discarded through the kill flag.
// Optional feature: define PC_FETCH_ALIGN_CHECK_EN to add the sticky
// ALIGN_ERR output and force redirect targets onto word boundaries.
import pc_fetch_pkg::*;

module pc_fetch_unit #(
    parameter logic [PC_WIDTH-1:0] RESET_PC = 32'h0040_0000
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                STALL,
    input  logic                BR_VALID,
    input  logic [PC_WIDTH-1:0] BR_TARGET,
    output logic                REQ_VALID,
    output logic [PC_WIDTH-1:0] REQ_ADDR,
    input  logic                REQ_READY,
    input  logic                RSP_VALID,
    input  logic [31:0]         RSP_DATA,
    output logic                INST_VALID,
    output logic [31:0]         INST,
    output logic [PC_WIDTH-1:0] INST_PC,
    input  logic                INST_READY
`ifdef PC_FETCH_ALIGN_CHECK_EN
    ,
    output logic                ALIGN_ERR
`endif
);

    fetch_state_t        state;
    logic                kill;
    logic [PC_WIDTH-1:0] pc;
    logic [PC_WIDTH-1:0] redirect_pc;
    logic                pc_inc;
    logic                req_fire;
    logic                handoff;

`ifdef PC_FETCH_ALIGN_CHECK_EN
    assign redirect_pc = word_align(BR_TARGET);
`else
    assign redirect_pc = BR_TARGET;
`endif

    // Request is masked during stall and while reset is held so memory
    // never sees a request from a half-initialised unit.
    assign REQ_VALID  = (state == S_REQ) && !STALL && !RST;
    assign REQ_ADDR   = pc;
    assign INST_VALID = (state == S_OUT);
    assign req_fire   = REQ_VALID && REQ_READY;
    assign handoff    = (state == S_OUT) && INST_READY && !STALL;
    assign pc_inc     = handoff && !BR_VALID;

    pc_reg #(
        .RESET_PC(RESET_PC)
    ) u_pc_reg (
        .CLK       (CLK),
        .RST       (RST),
        .load      (BR_VALID),
        .load_value(redirect_pc),
        .inc       (pc_inc),
        .pc        (pc)
    );

    // Fetch sequencing: state, kill flag and the instruction holding register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= S_REQ;
            kill    <= 1'b0;
            INST    <= '0;
            INST_PC <= '0;
        end else begin
            case (state)
                S_REQ: begin
                    if (req_fire) begin
                        state <= S_WAIT;
                        kill  <= BR_VALID;
                    end
                end
                S_WAIT: begin
                    if (RSP_VALID) begin
                        if (kill || BR_VALID) begin
                            kill  <= 1'b0;
                            state <= S_REQ;
                        end else begin
                            INST    <= RSP_DATA;
                            INST_PC <= pc;
                            state   <= S_OUT;
                        end
                    end else if (BR_VALID) begin
                        kill <= 1'b1;
                    end
                end
                S_OUT: begin
                    if (BR_VALID || handoff) begin
                        state <= S_REQ;
                    end
                end
                default: begin
                    state <= S_REQ;
                    kill  <= 1'b0;
                end
            endcase
        end
    end

`ifdef PC_FETCH_ALIGN_CHECK_EN
    // Sticky flag for any redirect aimed at a non-word-aligned address.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ALIGN_ERR <= 1'b0;
        end else if (BR_VALID && (BR_TARGET[1:0] != 2'b00)) begin
            ALIGN_ERR <= 1'b1;
        end
    end
`endif

endmodule
